// File: rtl/window_loader_if.sv
// window_loader_if: pixel stream in, 3x3 window plus centre coordinates out.
interface window_loader_if #(
    parameter int DATA_W  = 8,
    parameter int COORD_W = 8
);
    logic                  Enable;
    logic [DATA_W-1:0]     DataIn;
    logic [9*DATA_W-1:0]   DataOut;
    logic [COORD_W-1:0]    Out_Row;
    logic [COORD_W-1:0]    Out_Column;
    logic                  isReady;
    logic                  isEnd;

    modport master (
        output Enable, DataIn,
        input  DataOut, Out_Row, Out_Column, isReady, isEnd
    );

    modport slave (
        input  Enable, DataIn,
        output DataOut, Out_Row, Out_Column, isReady, isEnd
    );
endinterface

// File: rtl/window_loader.sv
// window_loader: raster stream to 3x3 windows using two line buffers.
// Define LOADER_ZERO_PAD_EN for zero-padded border windows (adds FLUSH).
module window_loader #(
    parameter int DATA_W  = 8,
    parameter int IMG_W   = 256,
    parameter int IMG_H   = 256,
    parameter int COORD_W = 8
) (
    input logic            CLK,
    input logic            Reset,
    window_loader_if.slave bus
);
    localparam int AW = $clog2(IMG_W);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
`ifdef LOADER_ZERO_PAD_EN
    localparam logic [1:0] FLUSH = 2'd2;
    localparam logic [COORD_W:0]   ROW_FLUSH = (COORD_W+1)'(IMG_H + 1);
    localparam logic [COORD_W-1:0] CROW_LAST = COORD_W'(IMG_H - 1);
`endif
    localparam logic [COORD_W:0]   ROW_LAST = (COORD_W+1)'(IMG_H - 1);
    localparam logic [COORD_W:0]   R1 = (COORD_W+1)'(1);
    localparam logic [COORD_W:0]   R2 = (COORD_W+1)'(2);
    localparam logic [COORD_W-1:0] COL_LAST = COORD_W'(IMG_W - 1);
    localparam logic [COORD_W-1:0] C1 = COORD_W'(1);
    localparam logic [COORD_W-1:0] C2 = COORD_W'(2);

    logic [1:0]          state;
    logic [COORD_W:0]    rowCnt;
    logic [COORD_W-1:0]  colCnt;
    logic [DATA_W-1:0]   lineBuf0 [IMG_W];
    logic [DATA_W-1:0]   lineBuf1 [IMG_W];
    logic [DATA_W-1:0]   win [9];
    logic                pend;
    logic                pendEnd;
    logic [COORD_W-1:0]  pendRow;
    logic [COORD_W-1:0]  pendCol;

    logic                step;
    logic                lastPix;
    logic                colWrap;
    logic                emit;
    logic [DATA_W-1:0]   pixIn;
    logic [DATA_W-1:0]   tapTop;
    logic [DATA_W-1:0]   tapMid;
    logic [COORD_W-1:0]  rowLo;
    logic [COORD_W-1:0]  cRow;
    logic [COORD_W-1:0]  cCol;
    logic [AW-1:0]       colIdx;
    logic [2:0]          rowOk;
    logic [2:0]          colOk;
    logic [9*DATA_W-1:0] tapsOut;

    assign colIdx  = colCnt[AW-1:0];
    assign tapTop  = lineBuf1[colIdx];
    assign tapMid  = lineBuf0[colIdx];
    assign colWrap = colCnt == COL_LAST;
    assign rowLo   = rowCnt[COORD_W-1:0];

`ifdef LOADER_ZERO_PAD_EN
    logic flushing;
    assign flushing = state == FLUSH;
    assign step     = flushing || bus.Enable;
    assign pixIn    = flushing ? '0 : bus.DataIn;
    assign lastPix  = flushing && rowCnt == ROW_FLUSH && colCnt == '0;
    // Centre lags the write position by IMG_W+1 linear steps.
    assign emit     = rowCnt >= R2 || (rowCnt == R1 && colCnt != '0);
    assign cRow     = (colCnt == '0) ? rowLo - C2 : rowLo - C1;
    assign cCol     = (colCnt == '0) ? COL_LAST : colCnt - C1;
    assign rowOk    = {pendRow != CROW_LAST, 1'b1, pendRow != '0};
    assign colOk    = {pendCol != COL_LAST, 1'b1, pendCol != '0};
`else
    assign step     = bus.Enable;
    assign pixIn    = bus.DataIn;
    assign lastPix  = rowCnt == ROW_LAST && colWrap;
    assign emit     = state != IDLE && rowCnt >= R2 && colCnt >= C2;
    assign cRow     = rowLo - C1;
    assign cCol     = colCnt - C1;
    assign rowOk    = 3'b111;
    assign colOk    = 3'b111;
`endif

    always_comb begin
        tapsOut = '0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                if (rowOk[i] && colOk[j])
                    tapsOut[(i*3+j)*DATA_W +: DATA_W] = win[i*3+j];
            end
        end
    end

    // Line RAM is never reset; stale rows are masked or never windowed.
    always_ff @(posedge CLK) begin
        if (step) begin
            lineBuf0[colIdx] <= pixIn;
            lineBuf1[colIdx] <= tapMid;
        end
    end

    always_ff @(posedge CLK) begin
        if (!Reset) begin
            state   <= IDLE;
            rowCnt  <= '0;
            colCnt  <= '0;
            pend    <= 1'b0;
            pendEnd <= 1'b0;
            pendRow <= '0;
            pendCol <= '0;
            for (int k = 0; k < 9; k++) win[k] <= '0;
        end else begin
            pend    <= step && emit;
            pendEnd <= step && emit && lastPix;
            if (step) begin
                for (int i = 0; i < 3; i++) begin
                    win[3*i]   <= win[3*i+1];
                    win[3*i+1] <= win[3*i+2];
                end
                win[2]  <= tapTop;
                win[5]  <= tapMid;
                win[8]  <= pixIn;
                pendRow <= cRow;
                pendCol <= cCol;
                if (lastPix) begin
                    rowCnt <= '0;
                    colCnt <= '0;
                end else if (colWrap) begin
                    colCnt <= '0;
                    rowCnt <= rowCnt + R1;
                end else begin
                    colCnt <= colCnt + C1;
                end
`ifdef LOADER_ZERO_PAD_EN
                if (lastPix)
                    state <= IDLE;
                else if (rowCnt == ROW_LAST && colWrap)
                    state <= FLUSH;
                else if (!flushing)
                    state <= RUN;
`else
                state <= lastPix ? IDLE : RUN;
`endif
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!Reset) begin
            bus.DataOut    <= '0;
            bus.Out_Row    <= '0;
            bus.Out_Column <= '0;
            bus.isReady    <= 1'b0;
            bus.isEnd      <= 1'b0;
        end else begin
            bus.isReady <= pend;
            bus.isEnd   <= pendEnd;
            if (pend) begin
                bus.DataOut    <= tapsOut;
                bus.Out_Row    <= pendRow;
                bus.Out_Column <= pendCol;
            end
        end
    end
endmodule

// File: tb/tb_window_loader.sv
// tb_window_loader: scoreboard bench for window_loader at 5x4 frames.
// Pad-mode scenario runs when LOADER_ZERO_PAD_EN is defined.
module tb_window_loader;
    localparam int W  = 5;
    localparam int H  = 4;
    localparam int DW = 8;
    localparam int CW = 8;

    typedef struct {
        logic [9*DW-1:0] taps;
        logic [CW-1:0]   row;
        logic [CW-1:0]   col;
        logic            last;
        int              acc;
    } exp_t;

    logic CLK = 1'b0;
    logic Reset = 1'b0;

    window_loader_if #(.DATA_W(DW), .COORD_W(CW)) bus ();

    window_loader #(
        .DATA_W(DW), .IMG_W(W), .IMG_H(H), .COORD_W(CW)
    ) dut (
        .CLK(CLK),
        .Reset(Reset),
        .bus(bus)
    );

    always #5 CLK = ~CLK;

    int edgeCnt = 0;
    always @(posedge CLK) edgeCnt++;

    int total = 0;
    int bad = 0;
    int winCnt = 0;
    int endCnt = 0;
    bit monOn = 1'b0;
    exp_t sb[$];
    exp_t got[$];
    logic [9*DW-1:0] holdTaps = '0;
    logic [CW-1:0] holdRow = '0;
    logic [CW-1:0] holdCol = '0;

    logic [DW-1:0] fr [H+2][W];
    int mr = 0;
    int mc = 0;

    function automatic logic [9*DW-1:0] pack9(input int a[9]);
        logic [9*DW-1:0] p;
        p = '0;
        for (int k = 0; k < 9; k++) p[k*DW +: DW] = DW'(a[k]);
        return p;
    endfunction

    task automatic modelStep(input logic [DW-1:0] v, input int acc);
        int cr;
        int cc;
        int rr;
        int c2;
        bit go;
        bit last;
        exp_t e;
        fr[mr][mc] = v;
        cr = 0;
        cc = 0;
`ifdef LOADER_ZERO_PAD_EN
        go = (mr*W + mc) >= W + 1;
        if (go) begin
            cr = (mr*W + mc - W - 1) / W;
            cc = (mr*W + mc - W - 1) % W;
        end
        last = mr == H + 1 && mc == 0;
`else
        go = mr >= 2 && mc >= 2;
        cr = mr - 1;
        cc = mc - 1;
        last = mr == H - 1 && mc == W - 1;
`endif
        if (go) begin
            e.taps = '0;
            for (int i = 0; i < 3; i++) begin
                for (int j = 0; j < 3; j++) begin
                    rr = cr - 1 + i;
                    c2 = cc - 1 + j;
                    if (rr >= 0 && rr < H && c2 >= 0 && c2 < W)
                        e.taps[(i*3+j)*DW +: DW] = fr[rr][c2];
                end
            end
            e.row = CW'(cr);
            e.col = CW'(cc);
            e.last = last;
            e.acc = acc;
            sb.push_back(e);
        end
`ifdef LOADER_ZERO_PAD_EN
        if (last) begin
            mr = 0;
            mc = 0;
        end else if (mc == W - 1) begin
            mc = 0;
            mr++;
        end else begin
            mc++;
        end
`else
        if (mc == W - 1) begin
            mc = 0;
            mr = (mr == H - 1) ? 0 : mr + 1;
        end else begin
            mc++;
        end
`endif
    endtask

    task automatic monitor();
        exp_t e;
        exp_t g;
        forever begin
            @(negedge CLK);
            if (monOn) begin
                if (bus.isReady === 1'b1) begin
                    winCnt++;
                    if (bus.isEnd === 1'b1) endCnt++;
                    g.taps = bus.DataOut;
                    g.row = bus.Out_Row;
                    g.col = bus.Out_Column;
                    g.last = bus.isEnd;
                    g.acc = edgeCnt;
                    got.push_back(g);
                    total++;
                    if (sb.size() == 0) begin
                        bad++;
                        $display("FAIL spurious window: row=%0d col=%0d, none required",
                                 bus.Out_Row, bus.Out_Column);
                    end else begin
                        e = sb.pop_front();
                        if ({bus.DataOut, bus.Out_Row, bus.Out_Column, bus.isEnd} !==
                            {e.taps, e.row, e.col, e.last}) begin
                            bad++;
                            $display("FAIL window: got %h r%0d c%0d end%b, required %h r%0d c%0d end%b",
                                     bus.DataOut, bus.Out_Row, bus.Out_Column, bus.isEnd,
                                     e.taps, e.row, e.col, e.last);
                        end
                        total++;
                        if (edgeCnt !== e.acc + 1) begin
                            bad++;
                            $display("FAIL latency: window at edge %0d, required %0d",
                                     edgeCnt, e.acc + 1);
                        end
                        holdTaps = e.taps;
                        holdRow = e.row;
                        holdCol = e.col;
                    end
                end else begin
                    total++;
                    if (bus.isEnd !== 1'b0) begin
                        bad++;
                        $display("FAIL isEnd without isReady: got %b required 0", bus.isEnd);
                    end
                    total++;
                    if ({bus.DataOut, bus.Out_Row, bus.Out_Column} !==
                        {holdTaps, holdRow, holdCol}) begin
                        bad++;
                        $display("FAIL hold: got %h r%0d c%0d, required %h r%0d c%0d",
                                 bus.DataOut, bus.Out_Row, bus.Out_Column,
                                 holdTaps, holdRow, holdCol);
                    end
                end
            end
        end
    endtask

    task automatic feed(input int n, input int base, input bit toggle);
        int i;
        bit phase;
        i = 0;
        phase = 1'b0;
        while (i < n) begin
            @(negedge CLK);
            if (toggle && phase) begin
                bus.Enable = 1'b0;
                bus.DataIn = DW'($urandom);
            end else begin
                bus.Enable = 1'b1;
                bus.DataIn = DW'(base + i);
            end
            @(posedge CLK);
            #1;
            if (bus.Enable) begin
                modelStep(bus.DataIn, edgeCnt);
                i++;
            end
            phase = ~phase;
        end
        @(negedge CLK);
        bus.Enable = 1'b0;
    endtask

    task automatic drain();
        repeat (4) @(posedge CLK);
        #1;
    endtask

    task automatic checkCounts(input string name, input int wins, input int ends);
        total++;
        if (winCnt !== wins) begin
            bad++;
            $display("FAIL %s windows: got %0d required %0d", name, winCnt, wins);
        end
        total++;
        if (endCnt !== ends) begin
            bad++;
            $display("FAIL %s isEnd pulses: got %0d required %0d", name, endCnt, ends);
        end
        total++;
        if (sb.size() !== 0) begin
            bad++;
            $display("FAIL %s pending windows: got %0d required 0", name, sb.size());
        end
    endtask

    task automatic checkWin(input string name, input int idx, input logic [9*DW-1:0] taps,
                            input int row, input int col, input bit last);
        exp_t g;
        g = (idx < got.size()) ? got[idx] : '{default: '0};
        total++;
        if ({g.taps, g.row, g.col, g.last} !== {taps, CW'(row), CW'(col), last}) begin
            bad++;
            $display("FAIL %s: got %h r%0d c%0d end%b, required %h r%0d c%0d end%b",
                     name, g.taps, g.row, g.col, g.last, taps, row, col, last);
        end
    endtask

    task automatic test_reset();
        @(negedge CLK);
        monOn = 1'b0;
        Reset = 1'b0;
        bus.Enable = 1'b0;
        bus.DataIn = '0;
        repeat (2) @(posedge CLK);
        #1;
        total++;
        if (bus.DataOut !== '0) begin
            bad++;
            $display("FAIL reset DataOut: got %h required 0", bus.DataOut);
        end
        total++;
        if (bus.Out_Row !== '0) begin
            bad++;
            $display("FAIL reset Out_Row: got %0d required 0", bus.Out_Row);
        end
        total++;
        if (bus.Out_Column !== '0) begin
            bad++;
            $display("FAIL reset Out_Column: got %0d required 0", bus.Out_Column);
        end
        total++;
        if (bus.isReady !== 1'b0) begin
            bad++;
            $display("FAIL reset isReady: got %b required 0", bus.isReady);
        end
        total++;
        if (bus.isEnd !== 1'b0) begin
            bad++;
            $display("FAIL reset isEnd: got %b required 0", bus.isEnd);
        end
        Reset = 1'b1;
        holdTaps = '0;
        holdRow = '0;
        holdCol = '0;
        sb.delete();
        got.delete();
        mr = 0;
        mc = 0;
        winCnt = 0;
        endCnt = 0;
        monOn = 1'b1;
    endtask

`ifndef LOADER_ZERO_PAD_EN
    task automatic test_continuous();
        got.delete();
        winCnt = 0;
        endCnt = 0;
        feed(20, 0, 1'b0);
        drain();
        checkCounts("continuous", 6, 1);
        checkWin("continuous first", 0, pack9('{0,1,2,5,6,7,10,11,12}), 1, 1, 1'b0);
        checkWin("continuous last", 5, pack9('{7,8,9,12,13,14,17,18,19}), 2, 3, 1'b1);
    endtask

    task automatic test_stall();
        got.delete();
        winCnt = 0;
        endCnt = 0;
        feed(20, 0, 1'b1);
        drain();
        checkCounts("stall", 6, 1);
        checkWin("stall first", 0, pack9('{0,1,2,5,6,7,10,11,12}), 1, 1, 1'b0);
        checkWin("stall last", 5, pack9('{7,8,9,12,13,14,17,18,19}), 2, 3, 1'b1);
    endtask

    task automatic test_mid_reset();
        got.delete();
        winCnt = 0;
        endCnt = 0;
        feed(9, 0, 1'b0);
        drain();
        checkCounts("partial frame", 0, 0);
        test_reset();
        feed(20, 0, 1'b0);
        drain();
        checkCounts("after reset", 6, 1);
        checkWin("after reset first", 0, pack9('{0,1,2,5,6,7,10,11,12}), 1, 1, 1'b0);
        checkWin("after reset last", 5, pack9('{7,8,9,12,13,14,17,18,19}), 2, 3, 1'b1);
    endtask

    task automatic test_back_to_back();
        got.delete();
        winCnt = 0;
        endCnt = 0;
        feed(40, 0, 1'b0);
        drain();
        checkCounts("back to back", 12, 2);
        checkWin("frame2 first", 6, pack9('{20,21,22,25,26,27,30,31,32}), 1, 1, 1'b0);
        checkWin("frame2 last", 11, pack9('{27,28,29,32,33,34,37,38,39}), 2, 3, 1'b1);
    endtask
`else
    task automatic test_zero_pad();
        got.delete();
        winCnt = 0;
        endCnt = 0;
        feed(20, 0, 1'b0);
        for (int k = 0; k < W + 1; k++) begin
            @(negedge CLK);
            bus.Enable = 1'b1;
            bus.DataIn = 8'hFF;
            @(posedge CLK);
            #1;
            modelStep(8'hFF, edgeCnt);
        end
        @(negedge CLK);
        bus.Enable = 1'b0;
        drain();
        checkCounts("zero pad", 20, 1);
        checkWin("pad first", 0, pack9('{0,0,0,0,0,1,0,5,6}), 0, 0, 1'b0);
        checkWin("pad last", 19, pack9('{13,14,0,18,19,0,0,0,0}), 3, 4, 1'b1);
        got.delete();
        winCnt = 0;
        endCnt = 0;
        feed(7, 100, 1'b0);
        drain();
        checkCounts("pad restart", 1, 0);
        checkWin("pad restart first", 0, pack9('{0,0,0,0,100,101,0,105,106}), 0, 0, 1'b0);
    endtask
`endif

    initial begin
        bus.Enable = 1'b0;
        bus.DataIn = '0;
        fork
            monitor();
        join_none
        test_reset();
`ifndef LOADER_ZERO_PAD_EN
        test_continuous();
        test_stall();
        test_mid_reset();
        test_back_to_back();
`else
        test_zero_pad();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
